difftest_csr_delta_queue: RTL and testbench

- Parametrised successor to the per-commit CSR-state difftest hook.
- Captures an N-entry CSR snapshot per enable cycle and compares it against a shadow copy of the last accepted snapshot.
- Queues only the changed CSRs in a small FIFO and serialises them, one CSR per beat, over a valid/ready stream to the difftest sink.
- Sits between the core's CSR file and the simulation-side difftest bridge. Backpressure from the sink never stalls the core; overflow is counted instead.

---
 rtl/difftest_pkg.sv | 39 +++
 rtl/difftest_csr_delta_queue_if.sv | 31 +++
 rtl/difftest_sync_fifo.sv | 59 +++++
 rtl/difftest_csr_delta_queue.sv | 199 +++++++++++++++++++
 tb/tb_difftest_csr_delta_queue.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/difftest_pkg.sv
// Shared difftest definitions: CSR ordering, default widths and the snapshot entry layout.
package difftest_pkg;

  localparam int unsigned NUM_DIFFTEST_CSRS = 18;
  localparam int unsigned DEFAULT_XLEN      = 64;
  localparam int unsigned DEFAULT_COREID_W  = 8;
  localparam int unsigned DEFAULT_SEQ_W     = 16;

  // Established difftest CSR order; privilege mode travels as CSR 0.
  typedef enum logic [4:0] {
    CSR_PRIV     = 5'd0,
    CSR_MSTATUS  = 5'd1,
    CSR_SSTATUS  = 5'd2,
    CSR_MEPC     = 5'd3,
    CSR_SEPC     = 5'd4,
    CSR_MTVAL    = 5'd5,
    CSR_STVAL    = 5'd6,
    CSR_MTVEC    = 5'd7,
    CSR_STVEC    = 5'd8,
    CSR_MCAUSE   = 5'd9,
    CSR_SCAUSE   = 5'd10,
    CSR_SATP     = 5'd11,
    CSR_MIP      = 5'd12,
    CSR_MIE      = 5'd13,
    CSR_MSCRATCH = 5'd14,
    CSR_SSCRATCH = 5'd15,
    CSR_MIDELEG  = 5'd16,
    CSR_MEDELEG  = 5'd17
  } csr_idx_e;

  // Queued snapshot for the default configuration: change mask, values, core id, sequence.
  typedef struct packed {
    logic [NUM_DIFFTEST_CSRS-1:0]              mask;
    logic [NUM_DIFFTEST_CSRS*DEFAULT_XLEN-1:0] csr;
    logic [DEFAULT_COREID_W-1:0]               coreid;
    logic [DEFAULT_SEQ_W-1:0]                  seq;
  } snapshot_entry_t;

endpackage

// File: rtl/difftest_csr_delta_queue_if.sv
// Beat stream from the CSR delta queue to the difftest sink.
interface difftest_csr_delta_queue_if
  import difftest_pkg::*;
#(
  parameter int unsigned XLEN     = DEFAULT_XLEN,
  parameter int unsigned NUM_CSRS = NUM_DIFFTEST_CSRS,
  parameter int unsigned COREID_W = DEFAULT_COREID_W,
  parameter int unsigned SEQ_W    = DEFAULT_SEQ_W
);

  localparam int unsigned IDX_W = $clog2(NUM_CSRS);

  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    out_index;
  logic [XLEN-1:0]     out_data;
  logic [COREID_W-1:0] out_coreid;
  logic [SEQ_W-1:0]    out_seq;
  logic                out_last;

  modport master (
    output out_valid, out_index, out_data, out_coreid, out_seq, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_index, out_data, out_coreid, out_seq, out_last,
    output out_ready
  );

endinterface

// File: rtl/difftest_sync_fifo.sv
// Register-based synchronous FIFO; a push into a full FIFO is taken when a pop frees the head slot.
module difftest_sync_fifo
  import difftest_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_c, do_pop_c;

  // Extra pointer bit separates full from empty when the slot indices match.
  always_comb begin
    empty_c   = (wr_ptr_q == rd_ptr_q);
    full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop_c  = pop && !empty_c;
    do_push_c = push && (!full_c || do_pop_c);
    head_c    = mem_q[rd_ptr_q[AW-1:0]];
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop_c) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/difftest_csr_delta_queue.sv
// Per-commit CSR delta capture: compares each snapshot to the last accepted one, queues
// changed CSRs and streams them one CSR per beat; sink backpressure drops snapshots, never stalls.
module difftest_csr_delta_queue
  import difftest_pkg::*;
#(
  parameter int unsigned XLEN      = DEFAULT_XLEN,
  parameter int unsigned NUM_CSRS  = NUM_DIFFTEST_CSRS,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned COREID_W  = DEFAULT_COREID_W,
  parameter int unsigned SEQ_W     = DEFAULT_SEQ_W,
  parameter bit          FULL_DUMP = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CSRS*XLEN-1:0] io_csr,
  input  logic [COREID_W-1:0]      io_coreid,
  difftest_csr_delta_queue_if.master out_if,
  output logic [SEQ_W-1:0]         drop_count,
  output logic                     overflow
);

  localparam int unsigned IDX_W  = $clog2(NUM_CSRS);
  localparam int unsigned CSRS_W = NUM_CSRS * XLEN;

  typedef struct packed {
    logic [NUM_CSRS-1:0] mask;
    logic [CSRS_W-1:0]   csr;
    logic [COREID_W-1:0] coreid;
    logic [SEQ_W-1:0]    seq;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  logic [CSRS_W-1:0]   shadow_q, shadow_d;
  logic                shadow_valid_q, shadow_valid_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [SEQ_W-1:0]    drop_count_q, drop_count_d;
  logic                overflow_q, overflow_d;

  logic [NUM_CSRS-1:0] wmask_q, wmask_d;
  logic                out_valid_q, out_valid_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;
  logic [XLEN-1:0]     out_data_q, out_data_d;
  logic [COREID_W-1:0] out_coreid_q, out_coreid_d;
  logic [SEQ_W-1:0]    out_seq_q, out_seq_d;
  logic                out_last_q, out_last_d;

  logic [NUM_CSRS-1:0] mask_c;
  logic [NUM_CSRS-1:0] rem_c;
  logic                push_c, pop_c;
  logic                fifo_full_c, fifo_empty_c;
  entry_t              push_entry_c;
  entry_t              head_c;
  logic [ENTRY_W-1:0]  head_raw_c;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CSRS-1:0] m);
    lowest_set = '0;
    for (int i = int'(NUM_CSRS) - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  function automatic logic single_bit(input logic [NUM_CSRS-1:0] m);
    return (m != '0) && ((m & (m - NUM_CSRS'(1))) == '0);
  endfunction

  function automatic logic [XLEN-1:0] csr_at(input logic [CSRS_W-1:0] v,
                                             input logic [IDX_W-1:0]  idx);
    return v[int'(idx)*XLEN +: XLEN];
  endfunction

  difftest_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .head_c    (head_raw_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  assign head_c = head_raw_c;

  // Change mask against the last accepted snapshot.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(NUM_CSRS); i++) begin
      mask_c[i] = (io_csr[i*XLEN +: XLEN] != shadow_q[i*XLEN +: XLEN]);
    end
    if (!shadow_valid_q || FULL_DUMP) mask_c = '1;
  end

  // Capture control: the shadow only advances when the snapshot is actually queued.
  always_comb begin
    shadow_d            = shadow_q;
    shadow_valid_d      = shadow_valid_q;
    seq_d               = seq_q;
    drop_count_d        = drop_count_q;
    overflow_d          = overflow_q;
    push_c              = 1'b0;
    push_entry_c.mask   = mask_c;
    push_entry_c.csr    = io_csr;
    push_entry_c.coreid = io_coreid;
    push_entry_c.seq    = seq_q;
    if (enable) begin
      seq_d = seq_q + SEQ_W'(1);
      if (mask_c != '0) begin
        if (!fifo_full_c || pop_c) begin
          push_c         = 1'b1;
          shadow_d       = io_csr;
          shadow_valid_d = 1'b1;
        end else begin
          if (drop_count_q != '1) drop_count_d = drop_count_q + SEQ_W'(1);
          overflow_d = 1'b1;
        end
      end
    end
  end

  // Serialiser: walk the head entry's mask lowest bit first; the head pops on its last beat.
  always_comb begin
    wmask_d      = wmask_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    out_data_d   = out_data_q;
    out_coreid_d = out_coreid_q;
    out_seq_d    = out_seq_q;
    out_last_d   = out_last_q;
    pop_c        = 1'b0;
    rem_c        = wmask_q & ~(NUM_CSRS'(1) << out_index_q);
    if (out_valid_q) begin
      if (out_if.out_ready) begin
        if (out_last_q) begin
          pop_c       = 1'b1;
          out_valid_d = 1'b0;
          wmask_d     = '0;
        end else begin
          wmask_d     = rem_c;
          out_index_d = lowest_set(rem_c);
          out_data_d  = csr_at(head_c.csr, lowest_set(rem_c));
          out_last_d  = single_bit(rem_c);
        end
      end
    end else if (!fifo_empty_c) begin
      wmask_d      = head_c.mask;
      out_valid_d  = 1'b1;
      out_index_d  = lowest_set(head_c.mask);
      out_data_d   = csr_at(head_c.csr, lowest_set(head_c.mask));
      out_coreid_d = head_c.coreid;
      out_seq_d    = head_c.seq;
      out_last_d   = single_bit(head_c.mask);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      seq_q          <= '0;
      drop_count_q   <= '0;
      overflow_q     <= 1'b0;
      wmask_q        <= '0;
      out_valid_q    <= 1'b0;
      out_index_q    <= '0;
      out_data_q     <= '0;
      out_coreid_q   <= '0;
      out_seq_q      <= '0;
      out_last_q     <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      seq_q          <= seq_d;
      drop_count_q   <= drop_count_d;
      overflow_q     <= overflow_d;
      wmask_q        <= wmask_d;
      out_valid_q    <= out_valid_d;
      out_index_q    <= out_index_d;
      out_data_q     <= out_data_d;
      out_coreid_q   <= out_coreid_d;
      out_seq_q      <= out_seq_d;
      out_last_q     <= out_last_d;
    end
  end

  assign out_if.out_valid  = out_valid_q;
  assign out_if.out_index  = out_index_q;
  assign out_if.out_data   = out_data_q;
  assign out_if.out_coreid = out_coreid_q;
  assign out_if.out_seq    = out_seq_q;
  assign out_if.out_last   = out_last_q;
  assign drop_count        = drop_count_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_difftest_csr_delta_queue.sv
// Bench for difftest_csr_delta_queue: directed scenarios plus random traffic against a
// queue-based model of snapshots, deltas, drops and beat order.
module tb_difftest_csr_delta_queue;
  import difftest_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned N     = NUM_DIFFTEST_CSRS;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned SW    = 16;

  typedef struct packed {
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
    logic [CW-1:0]   coreid;
    logic [SW-1:0]   seq;
    logic            last;
  } beat_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [N*XLEN-1:0] io_csr;
  logic [CW-1:0]     io_coreid;
  logic [SW-1:0]     drop_count, fd_drop_count;
  logic              overflow, fd_overflow;

  always #5 clock = ~clock;

  difftest_csr_delta_queue_if #(.XLEN(XLEN), .NUM_CSRS(N), .COREID_W(CW), .SEQ_W(SW)) dq_if ();
  difftest_csr_delta_queue_if #(.XLEN(XLEN), .NUM_CSRS(N), .COREID_W(CW), .SEQ_W(SW)) fd_if ();

  difftest_csr_delta_queue #(
    .XLEN(XLEN), .NUM_CSRS(N), .DEPTH(DEPTH), .COREID_W(CW), .SEQ_W(SW), .FULL_DUMP(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .io_csr(io_csr), .io_coreid(io_coreid),
    .out_if(dq_if), .drop_count(drop_count), .overflow(overflow)
  );

  difftest_csr_delta_queue #(
    .XLEN(XLEN), .NUM_CSRS(N), .DEPTH(DEPTH), .COREID_W(CW), .SEQ_W(SW), .FULL_DUMP(1'b1)
  ) dut_fd (
    .clock(clock), .reset(reset), .enable(enable), .io_csr(io_csr), .io_coreid(io_coreid),
    .out_if(fd_if), .drop_count(fd_drop_count), .overflow(fd_overflow)
  );

  int            nchk, npass, nfail;
  beat_t         exp_q[$];
  logic [XLEN-1:0] cur[N];
  logic [XLEN-1:0] sh[N];
  logic [CW-1:0] cur_core;
  bit            sh_valid;
  logic [SW-1:0] m_seq, m_drop;
  logic          m_ovf;
  int            outstanding;
  bit            stalled_prev;
  beat_t         saved;
  int            fd_idx, fd_beats, beats_seen;
  logic [SW-1:0] last_seq_seen;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t dut_beat();
    beat_t b;
    b.idx    = dq_if.out_index;
    b.data   = dq_if.out_data;
    b.coreid = dq_if.out_coreid;
    b.seq    = dq_if.out_seq;
    b.last   = dq_if.out_last;
    return b;
  endfunction

  // One clock: drive at the falling edge, check registered outputs, advance the model.
  task automatic cycle(input bit rst_i, input bit en_i, input bit rdy_i);
    beat_t         now, e, nb;
    bit            hs;
    logic [N-1:0]  mask;
    int            hi;
    reset     = rst_i;
    enable    = en_i;
    for (int i = 0; i < int'(N); i++) io_csr[i*XLEN +: XLEN] = cur[i];
    io_coreid = cur_core;
    dq_if.out_ready = rdy_i;
    #1;
    if (rst_i) begin
      exp_q.delete();
      sh_valid = 0; m_seq = '0; m_drop = '0; m_ovf = 1'b0; outstanding = 0;
      stalled_prev = 0; fd_idx = 0; fd_beats = 0;
    end else begin
      check("drop_count", 128'(drop_count), 128'(m_drop));
      check("overflow", 128'(overflow), 128'(m_ovf));
      now = dut_beat();
      if (stalled_prev) begin
        check("stall_valid", 128'(dq_if.out_valid), 128'(1'b1));
        check("stall_hold", 128'(now), 128'(saved));
      end
      hs = (dq_if.out_valid === 1'b1) && rdy_i;
      if (hs) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_beat", 128'(dq_if.out_valid), 128'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 128'(now), 128'(e));
          last_seq_seen = dq_if.out_seq;
          if (e.last) outstanding--;
        end
      end
      stalled_prev = (dq_if.out_valid === 1'b1) && !rdy_i;
      saved = now;
      if (fd_if.out_valid === 1'b1) begin
        check("fd_index", 128'(fd_if.out_index), 128'(fd_idx));
        check("fd_last", 128'(fd_if.out_last), 128'(fd_idx == int'(N) - 1));
        fd_idx = (fd_idx + 1) % int'(N);
        fd_beats++;
      end
      if (en_i) begin
        hi = 0;
        for (int i = 0; i < int'(N); i++) begin
          mask[i] = !sh_valid || (cur[i] != sh[i]);
          if (mask[i]) hi = i;
        end
        if (mask != '0) begin
          if (outstanding < int'(DEPTH)) begin
            for (int i = 0; i < int'(N); i++) begin
              if (mask[i]) begin
                nb.idx = 5'(i); nb.data = cur[i]; nb.coreid = cur_core;
                nb.seq = m_seq; nb.last = (i == hi);
                exp_q.push_back(nb);
              end
            end
            outstanding++;
            sh = cur;
            sh_valid = 1;
          end else begin
            if (m_drop != 16'hFFFF) m_drop++;
            m_ovf = 1'b1;
          end
        end
        m_seq++;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max) begin
      cycle(0, 0, 1);
      k++;
    end
    check("drain_done", 128'(exp_q.size()), 128'(0));
    cycle(0, 0, 1);
    cycle(0, 0, 1);
  endtask

  task automatic check_reset_state();
    check("rst_valid", 128'(dq_if.out_valid), 128'(1'b0));
    check("rst_index", 128'(dq_if.out_index), 128'(0));
    check("rst_data", 128'(dq_if.out_data), 128'(0));
    check("rst_coreid", 128'(dq_if.out_coreid), 128'(0));
    check("rst_seq", 128'(dq_if.out_seq), 128'(0));
    check("rst_last", 128'(dq_if.out_last), 128'(1'b0));
    check("rst_drop", 128'(drop_count), 128'(0));
    check("rst_ovf", 128'(overflow), 128'(1'b0));
  endtask

  task automatic randomize_all();
    for (int i = 0; i < int'(N); i++) cur[i] = {$urandom, $urandom};
  endtask

  initial begin
    int k;
    nchk = 0; npass = 0; nfail = 0; beats_seen = 0; last_seq_seen = '0;
    reset = 1'b1; enable = 1'b0; io_csr = '0; io_coreid = '0;
    dq_if.out_ready = 1'b0;
    fd_if.out_ready = 1'b1;
    cur_core = 8'h5A;
    for (int i = 0; i < int'(N); i++) cur[i] = '0;

    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check_reset_state();

    // Full first dump: CSR i carries i+1.
    for (int i = 0; i < int'(N); i++) cur[i] = 64'(i + 1);
    beats_seen = 0;
    cycle(0, 1, 1);
    drain(100);
    check("t1_beats", 128'(beats_seen), 128'(18));
    check("t1_seq", 128'(last_seq_seen), 128'(0));

    // Single mepc delta, then an identical snapshot, then a satp delta.
    cur[int'(CSR_MEPC)] = 64'h8000_0000;
    beats_seen = 0;
    cycle(0, 1, 1);
    drain(40);
    check("t2_beats", 128'(beats_seen), 128'(1));
    check("t2_seq", 128'(last_seq_seen), 128'(1));
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    check("t2_idle", 128'(dq_if.out_valid), 128'(1'b0));
    cur[int'(CSR_SATP)] = 64'hDEAD_BEEF_0000_0011;
    cycle(0, 1, 1);
    drain(40);
    check("t2_seq3", 128'(last_seq_seen), 128'(3));

    // Overflow under a stalled sink.
    cycle(1, 0, 0);
    for (int s = 0; s < 6; s++) begin
      randomize_all();
      cycle(0, 1, 0);
    end
    for (int s = 0; s < 4; s++) cycle(0, 0, 0);
    check("t3_drop", 128'(drop_count), 128'(2));
    check("t3_ovf", 128'(overflow), 128'(1'b1));
    drain(200);
    check("t3_seq", 128'(last_seq_seen), 128'(3));

    // Capture while full, in the cycle the head's last beat is taken.
    cycle(1, 0, 0);
    randomize_all();
    cycle(0, 1, 0);
    cur[5] = ~cur[5];  cycle(0, 1, 0);
    cur[7] = ~cur[7];  cycle(0, 1, 0);
    cur[9] = ~cur[9];  cycle(0, 1, 0);
    cycle(0, 0, 0);
    k = 0;
    while (!(dq_if.out_valid === 1'b1 && dq_if.out_last === 1'b1) && k < 40) begin
      cycle(0, 0, 1);
      k++;
    end
    check("t4_last_seen", 128'(dq_if.out_last), 128'(1'b1));
    cur[11] = ~cur[11];
    cycle(0, 1, 1);
    check("t4_drop", 128'(drop_count), 128'(0));
    check("t4_ovf", 128'(overflow), 128'(1'b0));
    drain(100);

    // Reset in the middle of a full dump.
    cycle(1, 0, 0);
    randomize_all();
    cycle(0, 1, 1);
    for (int s = 0; s < 6; s++) cycle(0, 0, 1);
    cycle(1, 0, 1);
    check_reset_state();
    beats_seen = 0;
    cycle(0, 1, 1);
    drain(100);
    check("t5_beats", 128'(beats_seen), 128'(18));
    check("t5_seq", 128'(last_seq_seen), 128'(0));

    // Identical snapshots: delta instance emits once, full-dump instance every time.
    cycle(1, 0, 0);
    randomize_all();
    beats_seen = 0;
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    drain(100);
    k = 0;
    while (fd_beats < 54 && k < 200) begin
      cycle(0, 0, 1);
      k++;
    end
    check("t6_fd_beats", 128'(fd_beats), 128'(54));
    check("t6_beats", 128'(beats_seen), 128'(18));

    // Random traffic against the model.
    cycle(1, 0, 0);
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < int'(N); i++) begin
        if ($urandom_range(5) == 0) cur[i] = {$urandom, $urandom};
      end
      if ($urandom_range(7) == 0) cur_core = 8'($urandom);
      cycle(0, 1'($urandom_range(1)), $urandom_range(3) != 0);
    end
    drain(400);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
